// File: rtl/pwm_multi.sv
// N-channel PWM sharing one period counter, with double-buffered ARR/CCR.
// Optional burst mode is compiled in with PWM_BURST_EN.
module pwm_multi #(
   parameter int W      = 32,
   parameter int N      = 4,
   parameter int CENTER = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cnt_en,
   input  logic           load,
   input  logic [W-1:0]   arr_in,
   input  logic [N*W-1:0] ccr_in,
   output logic [N-1:0]   o_pwm,
   output logic           period_tick,
   output logic [W-1:0]   cnt_val
`ifdef PWM_BURST_EN
   ,
   input  logic [15:0]    burst_len,
   output logic           burst_done
`endif
);

   logic [W-1:0]   cnt;
   logic [W-1:0]   cnt_nxt;
   logic           dir_up;
   logic           dir_nxt;
   logic [W-1:0]   shadow_arr;
   logic [W-1:0]   act_arr;
   logic [N*W-1:0] shadow_ccr;
   logic [N*W-1:0] act_ccr;
   logic [W-1:0]   next_arr;
   logic [N*W-1:0] next_ccr;
   logic [N-1:0]   pwm_nxt;
   logic           run;
   logic           upd;
   logic           burst_end;

   // A load coinciding with an update event goes straight to the active set.
   assign next_arr = load ? arr_in : shadow_arr;
   assign next_ccr = load ? ccr_in : shadow_ccr;

   assign upd = run && (cnt == '0) && ((CENTER == 0) || !dir_up);

`ifdef PWM_BURST_EN
   logic        en_d;
   logic        rise;
   logic [15:0] burst_cnt;
   logic [15:0] burst_lim;
   logic [15:0] cnt_eff;
   logic [15:0] lim_eff;

   // On the enable rising edge the burst state is being re-armed this cycle,
   // so use the fresh values rather than the stale registers.
   assign rise      = cnt_en && !en_d;
   assign run       = cnt_en && !(burst_done && !rise);
   assign cnt_eff   = rise ? 16'd0 : burst_cnt;
   assign lim_eff   = rise ? burst_len : burst_lim;
   assign burst_end = upd && (lim_eff != 16'd0) && ((cnt_eff + 16'd1) == lim_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_d       <= 1'b0;
         burst_cnt  <= '0;
         burst_lim  <= '0;
         burst_done <= 1'b0;
      end else begin
         en_d <= cnt_en;
         if (rise) begin
            burst_lim  <= burst_len;
            burst_cnt  <= '0;
            burst_done <= 1'b0;
         end
         if (upd)
            burst_cnt <= cnt_eff + 16'd1;
         if (burst_end)
            burst_done <= 1'b1;
      end
   end
`else
   assign run       = cnt_en;
   assign burst_end = 1'b0;
`endif

   always_comb begin
      cnt_nxt = cnt;
      dir_nxt = dir_up;
      if (!cnt_en) begin
         cnt_nxt = act_arr;
         dir_nxt = 1'b0;
      end else if (!run || burst_end) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
      end else if (CENTER == 0) begin
         cnt_nxt = upd ? next_arr : cnt - 1'b1;
      end else if (upd) begin
         // ARR=0 in centre mode never turns around: the counter sits at the valley.
         if (next_arr == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
         end else begin
            cnt_nxt = W'(1);
            dir_nxt = 1'b1;
         end
      end else if (dir_up) begin
         if (cnt >= act_arr) begin
            cnt_nxt = cnt - 1'b1;
            dir_nxt = 1'b0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end else begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   always_comb begin
      pwm_nxt = '0;
      if (run && !burst_end) begin
         for (int i = 0; i < N; i++)
            pwm_nxt[i] = (cnt < act_ccr[i*W +: W]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         dir_up      <= 1'b0;
         shadow_arr  <= '0;
         shadow_ccr  <= '0;
         act_arr     <= '0;
         act_ccr     <= '0;
         o_pwm       <= '0;
         period_tick <= 1'b0;
      end else begin
         if (load) begin
            shadow_arr <= arr_in;
            shadow_ccr <= ccr_in;
         end
         if (!cnt_en) begin
            act_arr <= shadow_arr;
            act_ccr <= shadow_ccr;
         end else if (upd) begin
            act_arr <= next_arr;
            act_ccr <= next_ccr;
         end
         cnt         <= cnt_nxt;
         dir_up      <= dir_nxt;
         o_pwm       <= pwm_nxt;
         period_tick <= upd;
      end
   end

   assign cnt_val = cnt;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: one edge-aligned and one centre-aligned instance
// share all inputs; burst checks are compiled in with PWM_BURST_EN.
module tb_pwm_multi;

   localparam int W = 16;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           cnt_en;
   logic           load;
   logic [W-1:0]   arr_in;
   logic [N*W-1:0] ccr_in;
   logic [N-1:0]   pwm_e, pwm_c;
   logic           tick_e, tick_c;
   logic [W-1:0]   cnt_e, cnt_c;
`ifdef PWM_BURST_EN
   logic [15:0]    burst_len;
   logic           bdone_e, bdone_c;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pwm_multi #(.W(W), .N(N), .CENTER(0)) dut_edge (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load),
      .arr_in(arr_in), .ccr_in(ccr_in),
      .o_pwm(pwm_e), .period_tick(tick_e), .cnt_val(cnt_e)
`ifdef PWM_BURST_EN
      , .burst_len(burst_len), .burst_done(bdone_e)
`endif
   );

   pwm_multi #(.W(W), .N(N), .CENTER(1)) dut_ctr (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load),
      .arr_in(arr_in), .ccr_in(ccr_in),
      .o_pwm(pwm_c), .period_tick(tick_c), .cnt_val(cnt_c)
`ifdef PWM_BURST_EN
      , .burst_len(burst_len), .burst_done(bdone_c)
`endif
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [W-1:0] arr, input logic [W-1:0] c0, input logic [W-1:0] c1);
      arr_in = arr;
      ccr_in = {c1, c0};
      load   = 1'b1;
      step(1);
      load   = 1'b0;
   endtask

   task automatic wait_tick(input bit sel_ctr, input int max, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int k = 0; k < max && !ok; k++) begin
         step(1);
         n++;
         if ((sel_ctr ? tick_c : tick_e) === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic window(input bit sel_ctr, input int n,
                         output int h0, output int h1, output int tk, output int mx);
      h0 = 0; h1 = 0; tk = 0; mx = 0;
      for (int k = 0; k < n; k++) begin
         step(1);
         if (sel_ctr) begin
            h0 += int'(pwm_c[0]); h1 += int'(pwm_c[1]); tk += int'(tick_c);
            if (int'(cnt_c) > mx) mx = int'(cnt_c);
         end else begin
            h0 += int'(pwm_e[0]); h1 += int'(pwm_e[1]); tk += int'(tick_e);
            if (int'(cnt_e) > mx) mx = int'(cnt_e);
         end
      end
   endtask

   task automatic test_reset;
      checks++; if (pwm_e !== 2'b00) begin errors++; $display("FAIL reset_pwm_e got %b want 00", pwm_e); end
      checks++; if (tick_e !== 1'b0) begin errors++; $display("FAIL reset_tick_e got %b want 0", tick_e); end
      checks++; if (cnt_e !== 16'd0) begin errors++; $display("FAIL reset_cnt_e got %0d want 0", cnt_e); end
      checks++; if (pwm_c !== 2'b00) begin errors++; $display("FAIL reset_pwm_c got %b want 00", pwm_c); end
      checks++; if (cnt_c !== 16'd0) begin errors++; $display("FAIL reset_cnt_c got %0d want 0", cnt_c); end
   endtask

   // ARR=9, ch0 CCR=3, ch1 CCR=0.
   task automatic test_edge_basic;
      int n, h0, h1, tk, mx;
      bit ok;
      do_load(16'd9, 16'd3, 16'd0);
      step(3);
      checks++; if (cnt_e !== 16'd9) begin errors++; $display("FAIL stopped_cnt got %0d want 9", cnt_e); end
      checks++; if (pwm_e !== 2'b00) begin errors++; $display("FAIL stopped_pwm got %b want 00", pwm_e); end
      cnt_en = 1'b1;
      step(1);
      checks++; if (cnt_e !== 16'd8) begin errors++; $display("FAIL first_run_cnt got %0d want 8", cnt_e); end
      wait_tick(1'b0, 20, n, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_tick_timeout got %0d cycles want tick", n); end
      checks++; if (cnt_e !== 16'd9) begin errors++; $display("FAIL basic_reload got %0d want 9", cnt_e); end
      window(1'b0, 10, h0, h1, tk, mx);
      checks++; if (h0 !== 3) begin errors++; $display("FAIL basic_ch0_high got %0d want 3", h0); end
      checks++; if (h1 !== 0) begin errors++; $display("FAIL basic_ch1_high got %0d want 0", h1); end
      checks++; if (tk !== 1 || tick_e !== 1'b1) begin errors++; $display("FAIL basic_ticks got %0d want 1 at period end", tk); end
   endtask

   // Starts aligned on a tick (counter=9); new ARR/CCR loaded mid-period.
   task automatic test_glitchless;
      int n, h0, h1, tk, mx;
      bit ok;
      step(3);
      do_load(16'd4, 16'd2, 16'd0);
      wait_tick(1'b0, 20, n, ok);
      checks++; if (ok !== 1'b1 || (4 + n) !== 10) begin errors++; $display("FAIL glitch_old_period got %0d want 10", 4 + n); end
      checks++; if (cnt_e !== 16'd4) begin errors++; $display("FAIL glitch_new_arr got %0d want 4", cnt_e); end
      window(1'b0, 5, h0, h1, tk, mx);
      checks++; if (h0 !== 2) begin errors++; $display("FAIL glitch_ch0_high got %0d want 2", h0); end
      checks++; if (tk !== 1 || tick_e !== 1'b1) begin errors++; $display("FAIL glitch_new_period got %0d ticks want 1", tk); end
   endtask

   task automatic test_saturate;
      int n, h0, h1, tk, mx, good;
      bit ok, ok2;
      do_load(16'd9, 16'd10, 16'd0);
      wait_tick(1'b0, 20, n, ok);
      wait_tick(1'b0, 20, n, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL sat_tick_timeout got %0d cycles want tick", n); end
      window(1'b0, 10, h0, h1, tk, mx);
      checks++; if (h0 !== 10) begin errors++; $display("FAIL sat_ccr_gt_arr got %0d want 10", h0); end
      checks++; if (h1 !== 0) begin errors++; $display("FAIL sat_ccr_zero got %0d want 0", h1); end
      do_load(16'd0, 16'd1, 16'd0);
      wait_tick(1'b0, 20, n, ok);
      step(2);
      good = 0;
      for (int k = 0; k < 6; k++) begin
         step(1);
         if (tick_e === 1'b1 && cnt_e === 16'd0 && pwm_e === 2'b01) good++;
      end
      checks++; if (good !== 6) begin errors++; $display("FAIL arr0_every_cycle got %0d good cycles want 6", good); end
   endtask

   // Stop/restart, then CCR==ARR (one low cycle) and CCR>ARR on ch1.
   task automatic test_stopped;
      int n, h0, h1, tk, mx;
      bit ok;
      cnt_en = 1'b0;
      do_load(16'd6, 16'd6, 16'd7);
      step(3);
      checks++; if (cnt_e !== 16'd6 || pwm_e !== 2'b00 || tick_e !== 1'b0) begin
         errors++; $display("FAIL stop_state got cnt=%0d pwm=%b tick=%b want 6/00/0", cnt_e, pwm_e, tick_e); end
      cnt_en = 1'b1;
      step(1);
      checks++; if (cnt_e !== 16'd5) begin errors++; $display("FAIL restart_cnt got %0d want 5", cnt_e); end
      wait_tick(1'b0, 20, n, ok);
      window(1'b0, 7, h0, h1, tk, mx);
      checks++; if (h0 !== 6) begin errors++; $display("FAIL ccr_eq_arr got %0d want 6", h0); end
      checks++; if (h1 !== 7) begin errors++; $display("FAIL ccr_above_arr got %0d want 7", h1); end
   endtask

   // Triangle visits the valley once per 2*ARR period, so high time is 2*CCR-1.
   task automatic test_center;
      int n, h0, h1, tk, mx;
      bit ok, ok2;
      do_load(16'd8, 16'd4, 16'd0);
      wait_tick(1'b1, 40, n, ok);
      wait_tick(1'b1, 40, n, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL ctr_tick_timeout got %0d cycles want tick", n); end
      checks++; if (cnt_c !== 16'd1) begin errors++; $display("FAIL ctr_after_valley got %0d want 1", cnt_c); end
      window(1'b1, 16, h0, h1, tk, mx);
      checks++; if (h0 !== 7) begin errors++; $display("FAIL ctr_high got %0d want 7", h0); end
      checks++; if (tk !== 1 || tick_c !== 1'b1) begin errors++; $display("FAIL ctr_period got %0d ticks want 1 in 16", tk); end
      checks++; if (mx !== 8) begin errors++; $display("FAIL ctr_peak got %0d want 8", mx); end
   endtask

   task automatic test_reset_mid;
      int n;
      bit ok, ok2;
      do_load(16'd9, 16'd3, 16'd0);
      wait_tick(1'b0, 20, n, ok);
      wait_tick(1'b0, 20, n, ok2);
      step(8);
      checks++; if (pwm_e !== 2'b01) begin errors++; $display("FAIL rst_precond_pwm got %b want 01", pwm_e); end
      #2 rst = 1'b1;
      #1;
      checks++; if (pwm_e !== 2'b00) begin errors++; $display("FAIL async_rst_pwm got %b want 00", pwm_e); end
      checks++; if (cnt_e !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", cnt_e); end
      checks++; if (tick_e !== 1'b0) begin errors++; $display("FAIL async_rst_tick got %b want 0", tick_e); end
      step(1);
      rst = 1'b0;
      step(5);
      checks++; if (pwm_e !== 2'b00 || pwm_c !== 2'b00) begin
         errors++; $display("FAIL post_rst_pwm got %b/%b want 00/00", pwm_e, pwm_c); end
      checks++; if (cnt_e !== 16'd0 || cnt_c !== 16'd0) begin
         errors++; $display("FAIL post_rst_cnt got %0d/%0d want 0/0", cnt_e, cnt_c); end
   endtask

`ifdef PWM_BURST_EN
   task automatic test_burst;
      int h0, h1, tk, mx;
      cnt_en    = 1'b0;
      burst_len = 16'd3;
      do_load(16'd4, 16'd2, 16'd0);
      step(4);
      cnt_en = 1'b1;
      window(1'b0, 40, h0, h1, tk, mx);
      checks++; if (tk !== 3) begin errors++; $display("FAIL burst_ticks got %0d want 3", tk); end
      checks++; if (bdone_e !== 1'b1 || pwm_e !== 2'b00 || cnt_e !== 16'd0) begin
         errors++; $display("FAIL burst_parked got done=%b pwm=%b cnt=%0d want 1/00/0", bdone_e, pwm_e, cnt_e); end
      cnt_en = 1'b0;
      step(2);
      checks++; if (bdone_e !== 1'b1) begin errors++; $display("FAIL burst_done_hold got %b want 1", bdone_e); end
      cnt_en = 1'b1;
      step(1);
      checks++; if (bdone_e !== 1'b0) begin errors++; $display("FAIL burst_done_clear got %b want 0", bdone_e); end
      window(1'b0, 40, h0, h1, tk, mx);
      checks++; if (tk !== 3 || bdone_e !== 1'b1) begin
         errors++; $display("FAIL burst_second got %0d ticks done=%b want 3/1", tk, bdone_e); end
      burst_len = 16'd0;
   endtask
`endif

   initial begin
      rst    = 1'b1;
      cnt_en = 1'b0;
      load   = 1'b0;
      arr_in = '0;
      ccr_in = '0;
`ifdef PWM_BURST_EN
      burst_len = 16'd0;
`endif
      step(2);
      rst = 1'b0;
      step(1);
      test_reset;
      test_edge_basic;
      test_glitchless;
      test_saturate;
      test_stopped;
      test_center;
      test_reset_mid;
`ifdef PWM_BURST_EN
      test_burst;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
